bcd_counter_n: RTL and testbench

//   Parametrised N-digit BCD up/down counter with synchronous parallel load,

---
 rtl/bcd_counter_n.sv | 55 +++++
 tb/tb_bcd_counter_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit BCD up/down counter with load, wrap/saturate and sticky overflow
`timescale 1ns/1ps
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  enable,
  input  logic                  load,
  input  logic                  up,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  co,
  output logic                  zero,
  output logic                  ovf
);
  logic [4*DIGITS-1:0] r_q, w_up, w_dn, w_ld;
  logic [DIGITS:0]     w_c9, w_c0;
  logic                r_ovf, w_term;
  // w_c9[k] / w_c0[k]: every digit below k is 9 / 0, i.e. digit k receives a carry / borrow
  always_comb begin
    w_c9 = '0;
    w_c0 = '0;
    w_c9[0] = 1'b1;
    w_c0[0] = 1'b1;
    w_up = '0;
    w_dn = '0;
    w_ld = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_up[4*k+:4] = !w_c9[k] ? r_q[4*k+:4] : r_q[4*k+:4] == 4'd9 ? 4'd0 : r_q[4*k+:4] + 4'd1;
      w_dn[4*k+:4] = !w_c0[k] ? r_q[4*k+:4] : r_q[4*k+:4] == 4'd0 ? 4'd9 : r_q[4*k+:4] - 4'd1;
      w_ld[4*k+:4] = d[4*k+:4] > 4'd9 ? 4'd9 : d[4*k+:4];
      w_c9[k+1] = w_c9[k] & (r_q[4*k+:4] == 4'd9);
      w_c0[k+1] = w_c0[k] & (r_q[4*k+:4] == 4'd0);
    end
    w_term = up ? w_c9[DIGITS] : w_c0[DIGITS];
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_q   <= w_ld;
      r_ovf <= 1'b0;
    end else if (enable) begin
      if (WRAP || !w_term) r_q <= up ? w_up : w_dn;
      if (w_term) r_ovf <= 1'b1;
    end
  end
  assign q    = r_q;
  assign ovf  = r_ovf;
  assign co   = enable & ~load & ~clr & w_term;
  assign zero = w_c0[DIGITS];
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: three counter variants driven in lockstep, checked against an integer model
`timescale 1ns/1ps
module tb_bcd_counter_n;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        up = 1'b1;
  logic [15:0] d = '0;
  logic [15:0] q_w, q_s;
  logic [3:0]  q_1;
  logic        co_w, co_s, co_1, zero_w, zero_s, zero_1, ovf_w, ovf_s, ovf_1;
  int tests = 0;
  int fails = 0;
  int mv[3];
  bit mo[3];
  int nd[3] = '{4, 4, 1};
  bit wr[3] = '{1'b1, 1'b0, 1'b1};

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_w (.clk(clk), .clr(clr), .enable(enable), .load(load),
    .up(up), .d(d), .q(q_w), .co(co_w), .zero(zero_w), .ovf(ovf_w));
  bcd_counter_n #(.DIGITS(4), .WRAP(1'b0)) u_s (.clk(clk), .clr(clr), .enable(enable), .load(load),
    .up(up), .d(d), .q(q_s), .co(co_s), .zero(zero_s), .ovf(ovf_s));
  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_1 (.clk(clk), .clr(clr), .enable(enable), .load(load),
    .up(up), .d(d[3:0]), .q(q_1), .co(co_1), .zero(zero_1), .ovf(ovf_1));

  always #5 clk = ~clk;

  function automatic int maxv(int n);
    int m = 1;
    for (int k = 0; k < n; k++) m = m * 10;
    return m - 1;
  endfunction

  function automatic int dval(logic [15:0] x, int n);
    int v = 0;
    for (int k = n - 1; k >= 0; k--) v = v * 10 + ((x[4*k+:4] > 4'd9) ? 9 : int'(x[4*k+:4]));
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(int v, int n);
    logic [15:0] x = '0;
    for (int k = 0; k < n; k++) begin
      x[4*k+:4] = 4'(v % 10);
      v = v / 10;
    end
    return x;
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      mo[i] = 1'b0;
    end
  endtask

  task automatic check_all(string tag);
    logic [15:0] qs[3];
    logic cs[3], zs[3], os[3];
    bit term;
    qs = '{q_w, q_s, {12'h0, q_1}};
    cs = '{co_w, co_s, co_1};
    zs = '{zero_w, zero_s, zero_1};
    os = '{ovf_w, ovf_s, ovf_1};
    for (int i = 0; i < 3; i++) begin
      term = up ? (mv[i] == maxv(nd[i])) : (mv[i] == 0);
      chk($sformatf("%s.q%0d", tag, i), qs[i], to_bcd(mv[i], nd[i]));
      chk($sformatf("%s.co%0d", tag, i), 16'(cs[i]), 16'(enable & ~load & ~clr & term));
      chk($sformatf("%s.zero%0d", tag, i), 16'(zs[i]), 16'(mv[i] == 0));
      chk($sformatf("%s.ovf%0d", tag, i), 16'(os[i]), 16'(mo[i]));
    end
  endtask

  task automatic tick(string tag);
    int m;
    for (int i = 0; i < 3; i++) begin
      m = maxv(nd[i]);
      if (clr) begin
        mv[i] = 0;
        mo[i] = 1'b0;
      end else if (load) begin
        mv[i] = dval(d, nd[i]);
        mo[i] = 1'b0;
      end else if (enable) begin
        if (up ? mv[i] == m : mv[i] == 0) begin
          mo[i] = 1'b1;
          if (wr[i]) mv[i] = up ? 0 : m;
        end else mv[i] = up ? mv[i] + 1 : mv[i] - 1;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_load(logic [15:0] v, string tag);
    load = 1'b1;
    d = v;
    tick(tag);
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] spec[6];
    spec = '{16'h9999, 16'h0000, 16'h9998, 16'h0001, 16'h0999, 16'h9000};
    model_reset();
    clr = 1'b1;
    #2;
    check_all("rst");
    tick("rst_edge");
    clr = 1'b0;
    // 1: asynchronous clear mid-count
    do_load(16'h0427, "t1_load");
    enable = 1'b1;
    up = 1'b1;
    #2;
    clr = 1'b1;
    model_reset();
    #1;
    check_all("t1_clr_async");
    chk("t1_q", q_w, 16'h0000);
    tick("t1_clr_edge");
    clr = 1'b0;
    enable = 1'b0;
    // 2: cascaded carry
    do_load(16'h0999, "t2_load");
    enable = 1'b1;
    up = 1'b1;
    #1;
    check_all("t2_pre");
    tick("t2_step");
    chk("t2_q", q_w, 16'h1000);
    // 3: wrap / saturate at all nines
    enable = 1'b0;
    do_load(16'h9998, "t3_load");
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick($sformatf("t3_s%0d", i));
    chk("t3_q_wrap", q_w, 16'h0001);
    chk("t3_q_sat", q_s, 16'h9999);
    chk("t3_ovf", 16'(ovf_w), 16'h1);
    // 4: down to zero, saturate, load clears ovf
    enable = 1'b0;
    do_load(16'h0001, "t4_load");
    enable = 1'b1;
    up = 1'b0;
    for (int i = 0; i < 3; i++) tick($sformatf("t4_s%0d", i));
    chk("t4_q_sat", q_s, 16'h0000);
    chk("t4_co_sat", 16'(co_s), 16'h1);
    chk("t4_q_wrap", q_w, 16'h9998);
    do_load(16'h0005, "t4_reload");
    chk("t4_ovf_clr", 16'(ovf_s), 16'h0);
    // 5: sanitised load then hold
    enable = 1'b0;
    do_load(16'hA5F3, "t5_load");
    chk("t5_q", q_w, 16'h9593);
    for (int i = 0; i < 5; i++) begin
      up = ~up;
      tick($sformatf("t5_h%0d", i));
    end
    chk("t5_hold", q_w, 16'h9593);
    // 6: load beats enable; single-digit wrap
    do_load(16'h0009, "t6_pre");
    enable = 1'b1;
    up = 1'b1;
    do_load(16'h1234, "t6_load");
    chk("t6_q", q_w, 16'h1234);
    clr = 1'b1;
    model_reset();
    #1;
    tick("t6_clr");
    clr = 1'b0;
    for (int i = 0; i < 12; i++) tick($sformatf("t6_u%0d", i));
    chk("t6_q1", {12'h0, q_1}, 16'h0002);
    // randomized
    for (int n = 0; n < 400; n++) begin
      load = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) == 0) ? spec[$urandom_range(0, 5)] : 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #1;
        clr = 1'b1;
        model_reset();
        #1;
        check_all("rnd_clr");
        tick("rnd_clr_edge");
        clr = 1'b0;
      end else begin
        #1;
        check_all("rnd_pre");
        tick("rnd");
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
